// File: rtl/mips_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mips_ctrl_pkg
//  Shared definitions for the multicycle MIPS control path.
//  Contains the opcode values, the FSM state encodings, the aluop,
//  alusrcb and pcsrc encodings, the control-word struct and the helper
//  that reports whether an opcode is supported.
//  Optional feature macro: MULTICYCLE_CTRL_BNE_EN (adds bne support).
// ----------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam int OP_W    = 6;
    localparam int ALUOP_W = 3;
    localparam int ST_W    = 4;

    // Opcodes (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // aluop encodings understood by aludec
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FSM states; 13-15 are never entered in normal operation
    typedef enum logic [ST_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    // Moore control word produced from the current state
    typedef struct packed {
        logic                pcwrite;
        logic                branch;
        logic                bne;
        logic                memwrite;
        logic                irwrite;
        logic                regwrite;
        logic                alusrca;
        logic [1:0]          alusrcb;
        logic                iord;
        logic                memtoreg;
        logic                regdst;
        logic [1:0]          pcsrc;
        logic [ALUOP_W-1:0]  aluop;
    } ctrl_t;

    // True for opcodes that DECODE can dispatch
    function automatic logic op_supported(input logic [OP_W-1:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
`ifdef MULTICYCLE_CTRL_BNE_EN
            OP_BNE:                                        ok = 1'b1;
`endif
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// ----------------------------------------------------------------------------
// mc_outdec
//  Combinational state -> control-word decoder for the multicycle control
//  FSM. Every field not named for a state is 0, so unused encodings
//  produce an all-zero (no strobe) control word.
//  Optional feature macro: MULTICYCLE_CTRL_BNE_EN (decodes BNEEX).
// Ports
//  state  in   state_t  current FSM state
//  ctrl   out  ctrl_t   control word for that state
// ----------------------------------------------------------------------------
module mc_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.iord    = 1'b0;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PCSRC_ALURES;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                ctrl.alusrcb = SRCB_IMMSH2;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regdst   = 1'b0;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REGB;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REGB;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.regdst   = 1'b0;
                ctrl.regwrite = 1'b1;
            end
            S_JEX: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_BNE_EN
            S_BNEEX: begin
                // Same datapath setup as beq; taken on the inverted flag
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REGB;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.bne     = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//  Main control FSM for the multicycle MIPS core. Holds the state register
//  and next-state logic; control outputs are Moore-decoded by mc_outdec.
//  pcen and illegal_op are the only outputs with a combinational input path.
//  Optional feature macro: MULTICYCLE_CTRL_BNE_EN (bne -> BNEEX state).
// Ports
//  clk         in   1  rising-edge clock
//  reset       in   1  asynchronous active-high, forces FETCH
//  op          in   6  instr[31:26] from IR
//  zero        in   1  ALU zero flag
//  pcen        out  1  PC register enable
//  memwrite    out  1  memory write strobe
//  irwrite     out  1  instruction register load
//  regwrite    out  1  register file write
//  alusrca     out  1  0 = PC, 1 = regA
//  alusrcb     out  2  B operand select
//  iord        out  1  0 = PC address, 1 = ALUOut address
//  memtoreg    out  1  write back the Data register
//  regdst      out  1  1 = rd, 0 = rt
//  pcsrc       out  2  next-PC select
//  aluop       out  3  to aludec
//  illegal_op  out  1  pulse when DECODE sees an unsupported opcode
//  state_dbg   out  4  current state encoding
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W    = mips_ctrl_pkg::OP_W,
    parameter int ALUOP_W = mips_ctrl_pkg::ALUOP_W,
    parameter int ST_W    = mips_ctrl_pkg::ST_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    output logic               pcen,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               iord,
    output logic               memtoreg,
    output logic               regdst,
    output logic [1:0]         pcsrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal_op,
    output logic [ST_W-1:0]    state_dbg
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // op only matters in DECODE and MEMADR; elsewhere the path is fixed
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:   state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPEEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    OP_BNE:       state_next = S_BNEEX;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = S_MEMWB;
            S_RTYPEEX: state_next = S_RTYPEWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            // Final states and any stray encoding all return to FETCH
            default:   state_next = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state (state_reg),
        .ctrl  (ctrl)
    );

    assign memwrite = ctrl.memwrite;
    assign irwrite  = ctrl.irwrite;
    assign regwrite = ctrl.regwrite;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign iord     = ctrl.iord;
    assign memtoreg = ctrl.memtoreg;
    assign regdst   = ctrl.regdst;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;

    // zero reaches pcen without a register so a branch resolves in one cycle
    assign pcen = ctrl.pcwrite | (ctrl.branch & zero) | (ctrl.bne & ~zero);

    assign illegal_op = (state_reg == S_DECODE) && !op_supported(op);

    assign state_dbg = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
//  Scoreboard bench for multicycle_ctrl: the expected state sequence and
//  control word of each instruction are queued when it is issued and
//  popped/compared cycle by cycle.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluop;
    logic       illegal_op;
    logic [3:0] state_dbg;

`ifdef MULTICYCLE_CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] cw;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [15:0] obs_cw;
    assign obs_cw = {pcen, memwrite, irwrite, regwrite, alusrca, alusrcb,
                     iord, memtoreg, regdst, pcsrc, aluop, illegal_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected control word straight from the per-state output table
    function automatic logic [15:0] exp_cw(input logic [3:0] s, input logic z, input logic ill);
        logic       e_pcen, e_mw, e_irw, e_rw, e_asa, e_iord, e_mtr, e_rd, e_ill;
        logic [1:0] e_asb, e_pcs;
        logic [2:0] e_aop;
        {e_pcen, e_mw, e_irw, e_rw, e_asa, e_iord, e_mtr, e_rd, e_ill} = '0;
        e_asb = 2'b00;
        e_pcs = 2'b00;
        e_aop = 3'b000;
        case (s)
            4'd0:  begin e_pcen = 1'b1; e_irw = 1'b1; e_asb = 2'b01; end
            4'd1:  begin e_asb = 2'b11; e_ill = ill; end
            4'd2:  begin e_asa = 1'b1; e_asb = 2'b10; end
            4'd3:  begin e_iord = 1'b1; end
            4'd4:  begin e_mtr = 1'b1; e_rw = 1'b1; end
            4'd5:  begin e_iord = 1'b1; e_mw = 1'b1; end
            4'd6:  begin e_asa = 1'b1; e_aop = 3'b010; end
            4'd7:  begin e_rd = 1'b1; e_rw = 1'b1; end
            4'd8:  begin e_asa = 1'b1; e_aop = 3'b001; e_pcs = 2'b01; e_pcen = z; end
            4'd9:  begin e_asa = 1'b1; e_asb = 2'b10; end
            4'd10: begin e_rw = 1'b1; end
            4'd11: begin e_pcs = 2'b10; e_pcen = 1'b1; end
            4'd12: begin e_asa = 1'b1; e_aop = 3'b001; e_pcs = 2'b01; e_pcen = ~z; end
            default: ;
        endcase
        return {e_pcen, e_mw, e_irw, e_rw, e_asa, e_asb, e_iord, e_mtr, e_rd, e_pcs, e_aop, e_ill};
    endfunction

    // Issue one instruction starting at a negedge in FETCH; returns at the
    // negedge of the following FETCH.
    task automatic run_instr(input logic [5:0] opc, input logic z, input string name);
        logic [3:0] path[$];
        logic       ill;
        exp_t       e;
        int         n;
        ill = 1'b0;
        path.push_back(4'd0);
        path.push_back(4'd1);
        case (opc)
            6'b100011: begin path.push_back(4'd2); path.push_back(4'd3); path.push_back(4'd4); end
            6'b101011: begin path.push_back(4'd2); path.push_back(4'd5); end
            6'b000000: begin path.push_back(4'd6); path.push_back(4'd7); end
            6'b001000: begin path.push_back(4'd9); path.push_back(4'd10); end
            6'b000100: path.push_back(4'd8);
            6'b000010: path.push_back(4'd11);
            6'b000101: if (BNE_EN) path.push_back(4'd12); else ill = 1'b1;
            default:   ill = 1'b1;
        endcase
        foreach (path[i]) begin
            e.st = path[i];
            e.cw = exp_cw(path[i], z, ill && (path[i] == 4'd1));
            sb_q.push_back(e);
        end
        n = path.size();
        for (int i = 0; i < n; i++) begin
            op   = opc;
            zero = z;
            // Final state of a multi-state instruction ignores op
            if (i == n - 1 && n > 2) op = 6'($urandom);
            #1;
            if (sb_q.size() == 0) begin
                check({name, " sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("%s c%0d state", name, i), 32'(state_dbg), 32'(e.st));
                check($sformatf("%s c%0d ctrl", name, i), 32'(obs_cw), 32'(e.cw));
            end
            @(negedge clk);
        end
        $display("instr %-6s op=%b zero=%b cycles=%0d illegal=%0d", name, opc, z, n, ill);
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'b000000;
        zero  = 1'b0;

        // Outputs show FETCH decode while reset is held
        @(negedge clk);
        #1;
        check("reset state", 32'(state_dbg), 32'd0);
        check("reset ctrl", 32'(obs_cw), 32'(exp_cw(4'd0, 1'b0, 1'b0)));
        @(negedge clk);
        reset = 1'b0;
        $display("reset released");

        run_instr(6'b100011, 1'b0, "lw");
        run_instr(6'b101011, 1'b1, "sw");
        run_instr(6'b000000, 1'($urandom), "rtype");
        run_instr(6'b001000, 1'b0, "addi");
        run_instr(6'b000100, 1'b1, "beq_t");
        run_instr(6'b000100, 1'b0, "beq_nt");
        run_instr(6'b000010, 1'b1, "j");
        run_instr(6'b111111, 1'b0, "ill");
        run_instr(6'b000101, 1'b0, "bne_nz");
        run_instr(6'b000101, 1'b1, "bne_z");

        // sw abandoned by reset in MEMADR: no memwrite must ever appear
        op   = 6'b101011;
        zero = 1'b0;
        #1;
        check("abort c0 state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        #1;
        check("abort c1 state", 32'(state_dbg), 32'd1);
        @(negedge clk);
        #1;
        check("abort c2 state", 32'(state_dbg), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("abort async state", 32'(state_dbg), 32'd0);
        check("abort async memwrite", 32'(memwrite), 32'd0);
        @(posedge clk);
        #1;
        check("abort held state", 32'(state_dbg), 32'd0);
        check("abort held memwrite", 32'(memwrite), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        $display("sw aborted by reset in MEMADR");

        // Back to normal operation after the abort
        run_instr(6'b100011, 1'b1, "lw2");
        for (int k = 0; k < 4; k++) begin
            run_instr(6'b000100, 1'($urandom), "beq_r");
        end

        check("sb drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
